// File: rtl/bin2bcd_disp_feeder.sv
// rtl/bin2bcd_disp_feeder.sv - sequential double-dabble binary-to-BCD feeder for the 7-segment scanner
module bin2bcd_disp_feeder #(
    parameter int DIV   = 50000,
    parameter int NBITS = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] bin,
    input  logic             load,
    input  logic [1:0]       dp_sel,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [15:0]      dat,
    output logic [1:0]       ptr,
    output logic             ce_disp
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = 16 + NBITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   sreg, sreg_nx, adj;
    logic [3:0]      iter, iter_nx;
    logic [15:0]     dat_nx;
    logic [1:0]      ptr_nx;
    logic            ovf_nx, done_nx;
    logic [CW-1:0]   div_cnt;

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        adj = sreg;
        for (int n = 0; n < 4; n++) begin
            if (sreg[NBITS + 4*n +: 4] >= 4'd5)
                adj[NBITS + 4*n +: 4] = sreg[NBITS + 4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        iter_nx  = iter;
        dat_nx   = dat;
        ptr_nx   = ptr;
        ovf_nx   = ovf;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    ptr_nx = dp_sel;
                    if (bin > NBITS'(9999)) begin
                        dat_nx  = 16'hEEEE;
                        ovf_nx  = 1'b1;
                        done_nx = 1'b1;
                    end else begin
                        sreg_nx  = {16'h0000, bin};
                        iter_nx  = 4'd0;
                        ovf_nx   = 1'b0;
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sreg_nx = {adj[SW-2:0], 1'b0};
                iter_nx = iter + 4'd1;
                if (iter == 4'(NBITS - 1)) begin
                    dat_nx   = sreg_nx[SW-1:NBITS];
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            iter  <= 4'd0;
            dat   <= 16'h0000;
            ptr   <= 2'b00;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            iter  <= iter_nx;
            dat   <= dat_nx;
            ptr   <= ptr_nx;
            ovf   <= ovf_nx;
            done  <= done_nx;
        end
    end

    // Scan tick runs freely, independent of conversions
    always_ff @(posedge clk) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (div_cnt == CW'(DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign ce_disp = (div_cnt == CW'(DIV - 1));
    assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_bin2bcd_disp_feeder.sv
// tb/tb_bin2bcd_disp_feeder.sv - directed self-checking bench for bin2bcd_disp_feeder
module tb_bin2bcd_disp_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] bin = '0;
    logic        load = 1'b0;
    logic [1:0]  dp_sel = '0;
    logic        busy, done, ovf, ce_disp;
    logic [15:0] dat;
    logic [1:0]  ptr;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    bin2bcd_disp_feeder #(.DIV(4), .NBITS(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin     (bin),
        .load    (load),
        .dp_sel  (dp_sel),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .dat     (dat),
        .ptr     (ptr),
        .ce_disp (ce_disp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; k counts edges since the last reset edge, ce expected at k%4==3
    task automatic step();
        logic r;
        r = rst_n;
        @(negedge clk);
        if (!r) k = 0;
        else    k++;
        chk($sformatf("ce_disp@k%0d", k), 32'(ce_disp), 32'((k % 4) == 3));
    endtask

    task automatic run_conv(input logic [13:0] b, input logic [1:0] d,
                            input logic [15:0] ed, input logic [1:0] ep,
                            input logic eo, input int elat, input int poke);
        logic [15:0] old;
        int first, nd, nb;
        old = dat; first = 0; nd = 0; nb = 0;
        bin = b; dp_sel = d; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                if (first == 0) first = i;
            end
            if (elat > 1 && i == elat - 1) chk("dat_hold", 32'(dat), 32'(old));
            if (i == poke) begin
                bin = 14'd777; dp_sel = 2'd3; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (i < 20) step();
        end
        chk($sformatf("latency_%0d", b), 32'(first), 32'(elat));
        chk($sformatf("busy_cycles_%0d", b), 32'(nb), (elat > 1) ? 32'd14 : 32'd0);
        chk($sformatf("done_count_%0d", b), 32'(nd), 32'd1);
        chk($sformatf("dat_%0d", b), 32'(dat), 32'(ed));
        chk($sformatf("ptr_%0d", b), 32'(ptr), 32'(ep));
        chk($sformatf("ovf_%0d", b), 32'(ovf), 32'(eo));
    endtask

    initial begin
        int nd;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        chk("rst_dat",  32'(dat),  32'h0000);
        chk("rst_ptr",  32'(ptr),  32'd0);
        chk("rst_ce",   32'(ce_disp), 32'd0);

        run_conv(14'd1234,  2'd2, 16'h1234, 2'd2, 1'b0, 15, 0);
        run_conv(14'd0,     2'd0, 16'h0000, 2'd0, 1'b0, 15, 0);
        run_conv(14'd9999,  2'd3, 16'h9999, 2'd3, 1'b0, 15, 0);
        run_conv(14'd10000, 2'd1, 16'hEEEE, 2'd1, 1'b1, 1,  0);
        run_conv(14'd16383, 2'd2, 16'hEEEE, 2'd2, 1'b1, 1,  0);
        run_conv(14'd42,    2'd0, 16'h0042, 2'd0, 1'b0, 15, 0);
        run_conv(14'd500,   2'd1, 16'h0500, 2'd1, 1'b0, 15, 5);

        // Reset in the middle of a conversion discards it
        bin = 14'd4321; dp_sel = 2'd2; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 1; i < 7; i++) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_dat",  32'(dat),  32'h0000);
        chk("mid_rst_ptr",  32'(ptr),  32'd0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) nd++;
        end
        chk("post_rst_idle", 32'(nd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_disp_feeder.md
Name: bin2bcd_disp_feeder

Overview:
Upstream stage of the 4-digit 7-segment scanner. Converts a 14-bit unsigned binary value to a 4-digit packed BCD word using sequential double-dabble, one iteration per clock. Holds the result as the scanner's 16-bit data word, registers the decimal-point position, and generates the scanner's digit-advance enable tick.

Parameters:
- DIV, 50000, ce_disp period in clk cycles; legal range 2..2^20.
- NBITS, 14, binary input width; fixed at 14 in this revision.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- bin  in  14  unsigned value to convert; sampled only on an accepted load.
- load  in  1  conversion request; accepted only in IDLE.
- dp_sel  in  2  decimal-point digit index; sampled with bin.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when dat/ovf are updated.
- ovf  out  1  sticky flag: last accepted bin was greater than 9999.
- dat  out  16  packed BCD to scanner: [15:12] thousands … [3:0] units.
- ptr  out  2  decimal-point index to scanner.
- ce_disp  out  1  one-cycle digit-scan enable tick.

Behaviour:
- Reset (rst_n=0 at a posedge), all state cleared:
  - State goes to IDLE; divider counter = 0.
  - busy=0, done=0, ovf=0, dat=16'h0000, ptr=2'b00, ce_disp=0.
  - Reset overrides everything, including a conversion in progress; the partial result is discarded.
- FSM states: IDLE, SHIFT.
- IDLE, load=1 at edge E0:
  - Capture dp_sel into ptr.
  - If bin > 9999: dat <= 16'hEEEE, ovf <= 1, done <= 1, stay in IDLE.
  - Otherwise: shift register <= {16'h0, bin}, iteration counter <= 0, ovf <= 0, go to SHIFT.
- SHIFT, each edge (one iteration):
  - Every BCD nibble >= 5 gets +3 (all four nibbles evaluated in parallel).
  - Then the 30-bit register shifts left by 1; counter increments.
  - On the 14th iteration (edge E14): dat <= BCD field of the shifted result, done <= 1, go to IDLE.
- Latency and flag timing:
  - Valid conversion: done is high in the cycle after E14, i.e. 14 clocks after the accepting edge. dat changes only at that edge.
  - Overflow path: done is high in the cycle after E0.
  - busy = 1 exactly while in SHIFT: 14 cycles, from after E0 through E14.
  - done is high for exactly one cycle per accepted load.
- load while busy: ignored, with no queueing; bin/dp_sel are not sampled.
- load held high: a new conversion starts on the first edge after returning to IDLE. This gives back-to-back operation with a 1-cycle IDLE gap between the E14 edge and the next accepting edge.
- dat and ptr hold their last values between conversions, so the display is stable during conversion.
- ce_disp:
  - Free-running counter 0..DIV-1 that wraps to 0.
  - ce_disp = 1 for the single cycle where the counter is DIV-1.
  - Period is exactly DIV clocks.
  - The counter runs independently of the FSM.
- Widths:
  - Internal shift register is 30 bits (16 BCD + 14 binary).
  - Nibble add-3 is 4-bit; no carry out of a nibble is possible after the >= 5 check.
  - The bin > 9999 compare is 14-bit unsigned.

Test Plan:
- Reset, then load bin=1234, dp_sel=2 → busy=1 for 14 cycles; done pulses at cycle 15 after load; dat=16'h1234, ptr=2, ovf=0.
- Load bin=0, then bin=9999 → dat=16'h0000, then dat=16'h9999; exactly one done pulse each; ovf stays 0.
- Load bin=10000, then bin=16383 → done the cycle after load, busy never asserted, dat=16'hEEEE, ovf=1. Next load bin=42 → dat=16'h0042, ovf cleared.
- Load bin=500; pulse load with bin=777 at cycle 5 of busy → dat=16'h0500, single done pulse, 777 never appears.
- Load bin=4321; assert rst_n=0 at cycle 7 of busy → next cycle busy=0, done=0, dat=16'h0000. No done pulse afterwards without a new load.
- DIV=4, run 20 cycles after reset → ce_disp high on cycles 4, 8, 12, 16, 20 (1-based from reset release), low otherwise, unaffected by concurrent conversions.
